// File: rtl/aes_round_pkg.sv
// Shared types and round-limit lookup for the AES round sequencer.
package aes_round_pkg;

  localparam int unsigned RND_CNT_W  = 5;
  localparam int unsigned NR_128_DEF = 10;
  localparam int unsigned NR_192_DEF = 12;
  localparam int unsigned NR_256_DEF = 14;

  typedef enum logic [1:0] {
    KM_128     = 2'd0,
    KM_192     = 2'd1,
    KM_256     = 2'd2,
    KM_ILLEGAL = 2'd3
  } key_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Final round index for a key mode; limits default to the standard AES values.
  function automatic logic [RND_CNT_W-1:0] nr_of(input key_mode_t   km,
                                                 input int unsigned nr128 = NR_128_DEF,
                                                 input int unsigned nr192 = NR_192_DEF,
                                                 input int unsigned nr256 = NR_256_DEF);
    case (km)
      KM_128:  return RND_CNT_W'(nr128);
      KM_192:  return RND_CNT_W'(nr192);
      KM_256:  return RND_CNT_W'(nr256);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_sequencer.sv
// AES round sequencer for 128/192/256-bit keys with start/busy/done handshake.
// Optional reverse counting for decryption: AES_ROUND_SEQ_DECRYPT_EN.
module aes_round_sequencer
  import aes_round_pkg::*;
#(
  parameter int unsigned CNT_W  = 5,
  parameter int unsigned NR_128 = NR_128_DEF,
  parameter int unsigned NR_192 = NR_192_DEF,
  parameter int unsigned NR_256 = NR_256_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       key_mode,
  input  logic             advance,
`ifdef AES_ROUND_SEQ_DECRYPT_EN
  input  logic             decrypt,
`endif
  output logic [CNT_W-1:0] round_count,
  output logic             busy,
  output logic             first_round,
  output logic             final_round,
  output logic             done,
  output logic             mode_err
);

  if ((32'(1) << CNT_W) <= NR_256) begin : g_cnt_w_chk
    $error("CNT_W is too narrow to hold NR_256");
  end

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] rc_q, rc_d;
  logic [CNT_W-1:0] nr_q, nr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] nr_sel;
  logic [CNT_W-1:0] start_val;
  logic [CNT_W-1:0] end_val;
  logic [CNT_W-1:0] rc_step;
  key_mode_t        km;

  assign km     = key_mode_t'(key_mode);
  assign nr_sel = CNT_W'(nr_of(km, NR_128, NR_192, NR_256));

`ifdef AES_ROUND_SEQ_DECRYPT_EN
  logic dec_q, dec_d;

  // Decryption walks the key schedule backwards: Nr down to 0.
  assign start_val = dec_q ? nr_q : '0;
  assign end_val   = dec_q ? '0 : nr_q;
  assign rc_step   = dec_q ? rc_q - CNT_W'(1) : rc_q + CNT_W'(1);
`else
  assign start_val = '0;
  assign end_val   = nr_q;
  assign rc_step   = rc_q + CNT_W'(1);
`endif

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    nr_d    = nr_q;
    err_d   = 1'b0;
`ifdef AES_ROUND_SEQ_DECRYPT_EN
    dec_d   = dec_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (km == KM_ILLEGAL) begin
            err_d = 1'b1;
          end else begin
            nr_d    = nr_sel;
            state_d = RUN;
`ifdef AES_ROUND_SEQ_DECRYPT_EN
            dec_d   = decrypt;
            rc_d    = decrypt ? nr_sel : '0;
`else
            rc_d    = '0;
`endif
          end
        end
      end
      RUN: begin
        if (advance) begin
          if (rc_q == end_val) state_d = DONE;
          else                 rc_d    = rc_step;
        end
      end
      DONE: begin
        rc_d    = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rc_q    <= '0;
      nr_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef AES_ROUND_SEQ_DECRYPT_EN
      dec_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      nr_q    <= nr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef AES_ROUND_SEQ_DECRYPT_EN
      dec_q   <= dec_d;
`endif
    end
  end

  assign round_count = rc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign mode_err    = err_q;
  assign first_round = (state_q == RUN) && (rc_q == start_val);
  assign final_round = (state_q == RUN) && (rc_q == end_val);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed self-checking bench for aes_round_sequencer.
module tb_aes_round_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] key_mode;
  logic       advance;
  logic [4:0] round_count;
  logic       busy;
  logic       first_round;
  logic       final_round;
  logic       done;
  logic       mode_err;
`ifdef AES_ROUND_SEQ_DECRYPT_EN
  logic       decrypt;
`endif

  int n_vec = 0;
  int n_err = 0;

  aes_round_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .key_mode    (key_mode),
    .advance     (advance),
`ifdef AES_ROUND_SEQ_DECRYPT_EN
    .decrypt     (decrypt),
`endif
    .round_count (round_count),
    .busy        (busy),
    .first_round (first_round),
    .final_round (final_round),
    .done        (done),
    .mode_err    (mode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full sequence with advance high except for an optional stall; noise
  // re-pulses start with key_mode 0 during RUN, which must be ignored.
  task automatic run_seq(input logic [1:0] km, input int nr, input bit dec,
                         input int stall_at, input int stall_n, input bit noise);
    int exp_rc;
    int st_v;
    int en_v;
    int stalled;
    st_v    = dec ? nr : 0;
    en_v    = dec ? 0 : nr;
    exp_rc  = st_v;
    stalled = 0;
    start    = 1'b1;
    key_mode = km;
    advance  = 1'b1;
`ifdef AES_ROUND_SEQ_DECRYPT_EN
    decrypt  = dec;
`endif
    tick();
    start = 1'b0;
    for (int c = 0; c < nr + 1 + stall_n; c++) begin
      chk("rc", round_count, exp_rc);
      chk("busy_run", busy, 1);
      chk("first", first_round, (exp_rc == st_v));
      chk("final", final_round, (exp_rc == en_v));
      chk("done_run", done, 0);
      chk("err_run", mode_err, 0);
      if (exp_rc == stall_at && stalled < stall_n) begin
        advance = 1'b0;
        stalled++;
      end else begin
        advance = 1'b1;
      end
      if (noise) begin
        start    = (c % 3 == 1);
        key_mode = 2'd0;
`ifdef AES_ROUND_SEQ_DECRYPT_EN
        decrypt  = ~dec;
`endif
      end
      tick();
      if (advance && exp_rc != en_v) exp_rc = dec ? exp_rc - 1 : exp_rc + 1;
    end
    start   = 1'b0;
    advance = 1'b1;
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 1);
    chk("first_done", first_round, 0);
    chk("final_done", final_round, 0);
    tick();
    chk("done_end", done, 0);
    chk("busy_end", busy, 0);
    chk("rc_end", round_count, 0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    key_mode = 2'd0;
    advance  = 1'b0;
`ifdef AES_ROUND_SEQ_DECRYPT_EN
    decrypt  = 1'b0;
`endif
    tick();
    tick();
    chk("rst_rc", round_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", mode_err, 0);
    chk("rst_first", first_round, 0);
    chk("rst_final", final_round, 0);
    rst = 1'b0;
    tick();

    // AES-128, no stall
    run_seq(2'd0, 10, 1'b0, -1, 0, 1'b0);

    // AES-256 with a three-cycle stall at round 5
    run_seq(2'd2, 14, 1'b0, 5, 3, 1'b0);

    // Illegal key mode, then a legal start
    start    = 1'b1;
    key_mode = 2'd3;
    tick();
    start = 1'b0;
    chk("err_pulse", mode_err, 1);
    chk("err_busy", busy, 0);
    chk("err_rc", round_count, 0);
    tick();
    chk("err_clear", mode_err, 0);
    chk("err_busy2", busy, 0);
    run_seq(2'd0, 10, 1'b0, -1, 0, 1'b0);

    // AES-192 with start/key_mode noise during RUN
    run_seq(2'd1, 12, 1'b0, -1, 0, 1'b1);

    // Asynchronous reset at round 7
    start    = 1'b1;
    key_mode = 2'd0;
    advance  = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("pre_rst_rc", round_count, 7);
    chk("pre_rst_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rc", round_count, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end

`ifdef AES_ROUND_SEQ_DECRYPT_EN
    // Decrypt, AES-192: 12 down to 0
    run_seq(2'd1, 12, 1'b1, -1, 0, 1'b0);
    // Encrypt still counts up afterwards
    run_seq(2'd0, 10, 1'b0, -1, 0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
